// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

   // Frame format shared by the transmitter and the receiver
   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Receiver FSM states
   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_STOP    = 3'd3,
      RX_RECOVER = 3'd4
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; second flop gives it a full cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver feeding an RX FIFO
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
   input  logic                 rx_clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 fifo_full,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 wr_EN,
   output logic                 frame_err,
   output logic                 overrun_err
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Mid-start-bit sample point and end-of-bit sample point
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;

   rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 wr_q, wr_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (rx_clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   // State, counters, shift register and output registers
   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         wr_q      <= wr_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
      end
   end

   // Next-state and datapath decisions; everything is judged on rx_s only
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      wr_d      = 1'b0;
      fe_d      = 1'b0;
      ov_d      = 1'b0;

      case (state_q)
         RX_IDLE: begin
            if (rx_s == START_BIT) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end

         RX_START: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HALF_LAST) begin
               if (rx_s == START_BIT) begin
                  // Start bit confirmed at its midpoint; data sampling is now bit-centred
                  state_d   = RX_DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end else begin
                  // Low pulse shorter than half a bit: treat as line noise
                  state_d = RX_IDLE;
               end
            end
         end

         RX_DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == IDX_LAST) begin
                  state_d = RX_STOP;
               end
            end
         end

         RX_STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s == STOP_BIT) begin
                  // Re-arm early so a start bit directly after the stop bit is caught
                  state_d = RX_IDLE;
                  if (fifo_full) begin
                     ov_d = 1'b1;
                  end else begin
                     data_d = shift_q;
                     wr_d   = 1'b1;
                  end
               end else begin
                  fe_d    = 1'b1;
                  state_d = RX_RECOVER;
               end
            end
         end

         RX_RECOVER: begin
            // A break keeps the line low; wait for it to return high before re-arming
            if (rx_s == STOP_BIT) begin
               state_d = RX_IDLE;
            end
         end

         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign data_out    = data_q;
   assign wr_EN       = wr_q;
   assign frame_err   = fe_q;
   assign overrun_err = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

   localparam int OS    = 16;
   localparam int LAT   = 3 + OS / 2 + 9 * OS;
   localparam logic [1:0] EV_WR = 2'd1;
   localparam logic [1:0] EV_FE = 2'd2;
   localparam logic [1:0] EV_OV = 2'd3;

   logic       rx_clk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rx     = 1'b1;
   logic       fifo_full = 1'b0;
   logic [7:0] data_out;
   logic       wr_EN;
   logic       frame_err;
   logic       overrun_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] last_good = 8'h00;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   uart_receiver #(
      .OVERSAMPLE (OS)
   ) dut (
      .rx_clk      (rx_clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .fifo_full   (fifo_full),
      .data_out    (data_out),
      .wr_EN       (wr_EN),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 rx_clk = ~rx_clk;

   // Edge counter: holds N from just after rising edge N
   always @(posedge rx_clk) cyc <= cyc + 1;

   // Log every output pulse with the edge that produced it
   always @(negedge rx_clk) begin
      if (wr_EN)       got_q.push_back({EV_WR, data_out, cyc[21:0]});
      if (frame_err)   got_q.push_back({EV_FE, 8'h00, cyc[21:0]});
      if (overrun_err) got_q.push_back({EV_OV, 8'h00, cyc[21:0]});
   end

   // Reference: frame outcome depends only on stop value and fifo_full
   task automatic model_frame(input int start, input logic [7:0] b,
                              input logic stop_val, input logic full);
      logic [21:0] t;
      t = 22'(start + LAT);
      if (!stop_val)  exp_q.push_back({EV_FE, 8'h00, t});
      else if (full)  exp_q.push_back({EV_OV, 8'h00, t});
      else begin
         exp_q.push_back({EV_WR, b, t});
         last_good = b;
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      if (n > 0) begin
         repeat (n) @(posedge rx_clk);
         #1;
      end
   endtask

   // Called 1 time unit after a rising edge; returns aligned the same way
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic full);
      logic [9:0] bits;
      bits = {stop_val, b, 1'b0};
      fifo_full = full;
      model_frame(cyc, b, stop_val, full);
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (OS) @(posedge rx_clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge rx_clk);
      #1;
      n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
      n_checks++; if (wr_EN !== 1'b0) begin n_fail++; $display("FAIL reset_wr_EN: got %b want 0", wr_EN); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
      rst_n = 1'b1;
      idle(10);
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL reset_no_events: got %0d want 0", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL single_hold: got %h want %h", data_out, last_good); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", data_out, last_good); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_frame_err();
      send_frame(8'h5A, 1'b0, 1'b0);
      idle(20);
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL ferr_hold: got %h want %h", data_out, last_good); end
      send_frame(8'h11, 1'b1, 1'b0);
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ferr_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (4) @(posedge rx_clk);
      #1;
      idle(30);
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_quiet: got %0d events want 0", got_q.size()); end
      send_frame(8'h81, 1'b1, 1'b0);
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_overrun();
      send_frame(8'hC3, 1'b1, 1'b1);
      fifo_full = 1'b0;
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL ovr_hold: got %h want %h", data_out, last_good); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [9:0] bits;
      bits = {1'b1, 8'hF0, 1'b0};
      // Start bit plus three data bits, then half of the fourth
      for (int i = 0; i < 4; i++) begin
         rx = bits[i];
         repeat (OS) @(posedge rx_clk);
         #1;
      end
      rx = bits[4];
      repeat (OS / 2) @(posedge rx_clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_out: got %h want 00", data_out); end
      n_checks++; if ({wr_EN, frame_err, overrun_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {wr_EN, frame_err, overrun_err}); end
      rx = 1'b1;
      repeat (4) @(posedge rx_clk);
      #1;
      rst_n = 1'b1;
      last_good = 8'h00;
      idle(20);
      send_frame(8'h0F, 1'b1, 1'b0);
      idle(8);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic       stop_val;
      logic       full;
      logic       prev_bad;
      logic [7:0] b;
      prev_bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         b        = 8'($urandom);
         stop_val = ($urandom_range(0, 5) != 0);
         full     = ($urandom_range(0, 3) == 0);
         idle(prev_bad ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 40)));
         send_frame(b, stop_val, full);
         prev_bad = !stop_val;
      end
      fifo_full = 1'b0;
      idle(20);
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL rand_hold: got %h want %h", data_out, last_good); end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
